// File: rtl/tl_ctrl_pkg.sv
// Shared definitions for the traffic-light controller and its datapath.
// State bit positions, one-hot encodings and next-state constants.
package tl_ctrl_pkg;

    localparam int STATE_W = 4;
    localparam int S_INIT  = 0;
    localparam int S_G     = 1;
    localparam int S_Y     = 2;
    localparam int S_R     = 3;
    localparam int WDOG_W  = 11;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 4'b0000,
        ST_INIT = 4'b0001,
        ST_G    = 4'b0010,
        ST_Y    = 4'b0100,
        ST_R    = 4'b1000
    } state_t;

    // Successor of each state on an accepted expiry
    localparam state_t NXT_IDLE = ST_INIT;
    localparam state_t NXT_INIT = ST_G;
    localparam state_t NXT_G    = ST_Y;
    localparam state_t NXT_Y    = ST_R;
    localparam state_t NXT_R    = ST_G;

    // True when at most one bit is set
    function automatic logic onehot0(input logic [STATE_W-1:0] v);
        return (v & (v - 1'b1)) == '0;
    endfunction

endpackage

// File: rtl/tl_ctrl_if.sv
// Controller <-> light datapath bus.
// master = controller, slave = datapath.
interface tl_ctrl_if;
    import tl_ctrl_pkg::*;

    logic [STATE_W-1:0] state;
    logic [STATE_W-1:0] int_flags;
    logic               cnt_rst;
    logic               dp_rst;

    modport master (
        output state,
        output cnt_rst,
        output dp_rst,
        input  int_flags
    );

    modport slave (
        input  state,
        input  cnt_rst,
        input  dp_rst,
        output int_flags
    );

endinterface

// File: rtl/tl_guard_cnt.sv
// Loadable counter with terminal flag: down to zero, or up to LIMIT.
// Used both as the post-entry flag guard and as the watchdog.
module tl_guard_cnt #(
    parameter int W     = 2,
    parameter bit UP    = 1'b0,
    parameter int LIMIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         run,
    input  logic [W-1:0] load_val,
    output logic         hit
);

    logic [W-1:0] cnt;

    assign hit = UP ? (cnt == W'(LIMIT)) : (cnt == '0);

    // Load wins; otherwise count toward the terminal value and hold there
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && !hit) begin
            cnt <= UP ? cnt + 1'b1 : cnt - 1'b1;
        end
    end

endmodule

// File: rtl/tl_ctrl.sv
// Traffic-light controller: IDLE -> INIT -> G -> Y -> R -> G ...
// Optional watchdog restart to INIT when TL_CTRL_WDOG_EN is defined.
module tl_ctrl
    import tl_ctrl_pkg::*;
#(
    parameter int GUARD    = 2,
    parameter int ROUND_W  = 8,
    parameter int WDOG_MAX = 2047
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    tl_ctrl_if.master          bus,
    output logic [ROUND_W-1:0] round_cnt,
    output logic               wdog_err
);

    localparam int GW = (GUARD > 1) ? $clog2(GUARD + 1) : 1;

    state_t cur;
    state_t nxt;
    logic   cnt_rst_q;
    logic   guard_zero;
    logic   accept;
    logic   rnd_inc;
    logic   wd_trip;
    logic   entry;

    assign bus.state   = cur;
    assign bus.cnt_rst = cnt_rst_q;
    assign bus.dp_rst  = ~reset;

    // Stale flags are masked for GUARD cycles after every entry
    tl_guard_cnt #(
        .W     (GW),
        .UP    (1'b0),
        .LIMIT (0)
    ) u_guard (
        .clk      (clk),
        .reset    (reset),
        .load     (entry),
        .run      (1'b1),
        .load_val (GW'(GUARD)),
        .hit      (guard_zero)
    );

    assign accept = guard_zero && |(cur & bus.int_flags);

`ifdef TL_CTRL_WDOG_EN
    logic wd_hit;
    logic wdog_err_q;

    // Cycles spent in the current non-idle state
    tl_guard_cnt #(
        .W     (WDOG_W),
        .UP    (1'b1),
        .LIMIT (WDOG_MAX)
    ) u_wdog (
        .clk      (clk),
        .reset    (reset),
        .load     (entry),
        .run      (cur != ST_IDLE),
        .load_val ('0),
        .hit      (wd_hit)
    );

    assign wdog_err = wdog_err_q;

    // Sticky error; cleared only by reset or by en forcing IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdog_err_q <= 1'b0;
        end else if (wd_trip) begin
            wdog_err_q <= 1'b1;
        end else if (!en) begin
            wdog_err_q <= 1'b0;
        end
    end
`else
    assign wdog_err = 1'b0;
`endif

    // Next state: en=0 first, then expiry, then watchdog
    always_comb begin
        nxt     = cur;
        rnd_inc = 1'b0;
        wd_trip = 1'b0;
        if (!en || !onehot0(cur)) begin
            nxt = ST_IDLE;
        end else if (cur == ST_IDLE) begin
            nxt = NXT_IDLE;
        end else if (accept) begin
            unique case (1'b1)
                cur[S_INIT]: nxt = NXT_INIT;
                cur[S_G]:    nxt = NXT_G;
                cur[S_Y]:    nxt = NXT_Y;
                cur[S_R]: begin
                    nxt     = NXT_R;
                    rnd_inc = 1'b1;
                end
                default:     nxt = ST_IDLE;
            endcase
        end else begin
`ifdef TL_CTRL_WDOG_EN
            if (wd_hit) begin
                nxt     = ST_INIT;
                wd_trip = 1'b1;
            end
`endif
        end
        entry = (nxt != cur) || wd_trip;
    end

    // State register with registered entry pulse and round counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur       <= ST_IDLE;
            cnt_rst_q <= 1'b0;
            round_cnt <= '0;
        end else begin
            cur       <= nxt;
            cnt_rst_q <= entry;
            if (rnd_inc) begin
                round_cnt <= round_cnt + 1'b1;
            end
        end
    end

endmodule
